// File: rtl/trap_controller.sv
// ============================================================================
// trap_controller: trap CSRs (mstatus/mtvec/mepc/mcause/mtval), trap and MRET
// redirect to fetch. Optional macro: TRAP_VECTORED_MODE_EN (vectored mtvec).
// Revision: 1.0
// ============================================================================
`default_nettype none

module trap_controller #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0100,
  parameter int          XLEN        = 32
) (
  input  logic            i_Clock,
  input  logic            i_Reset_n,
  input  logic            i_Valid,
  input  logic            i_ExceptionRaised,
  input  logic            i_Interrupt,
  input  logic [3:0]      i_ExceptionCause,
  input  logic [XLEN-1:0] i_TrapPC,
  input  logic [XLEN-1:0] i_TrapValue,
  input  logic            i_Mret,
  input  logic            i_CsrWriteEnable,
  input  logic [11:0]     i_CsrAddress,
  input  logic [XLEN-1:0] i_CsrWriteData,
  output logic [XLEN-1:0] o_CsrReadData,
  output logic            o_CsrHit,
  output logic            o_InterruptsEnabled,
  output logic            o_Busy,
  output logic            o_RedirectValid,
  output logic [XLEN-1:0] o_RedirectPC,
  input  logic            i_RedirectReady
);

  localparam logic [0:0] S_IDLE     = 1'b0;
  localparam logic [0:0] S_REDIRECT = 1'b1;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  logic [0:0]      state;
  logic [0:0]      state_next;

  logic [XLEN-1:0] mepc;
  logic [XLEN-1:0] mcause;
  logic [XLEN-1:0] mtval;
  logic [XLEN-1:0] mtvec;
  logic            mie;
  logic            mpie;
  logic [XLEN-1:0] redirect_pc;

  logic            is_idle;
  logic            trap_take;
  logic            mret_take;
  logic            csr_write;
  logic [XLEN-1:0] trap_base;
  logic [XLEN-1:0] trap_target;
  logic [XLEN-1:0] mtvec_wdata;
  logic [XLEN-1:0] mstatus_view;

  assign is_idle   = (state == S_IDLE);
  assign trap_take = is_idle & i_Valid & i_ExceptionRaised;
  assign mret_take = is_idle & i_Valid & i_Mret & ~i_ExceptionRaised;
  // A CSR write that collides with a trap or MRET is dropped, not deferred.
  assign csr_write = is_idle & i_CsrWriteEnable & ~trap_take & ~mret_take;

  assign trap_base = {mtvec[XLEN-1:2], 2'b00};

`ifdef TRAP_VECTORED_MODE_EN
  always_comb begin
    trap_target = trap_base;
    if ((mtvec[1:0] == 2'b01) && i_Interrupt) begin
      trap_target = trap_base + {{(XLEN-6){1'b0}}, i_ExceptionCause, 2'b00};
    end
  end

  // Only direct (00) and vectored (01) modes exist; reserved modes fall back to 00.
  assign mtvec_wdata = {i_CsrWriteData[XLEN-1:2],
                        (i_CsrWriteData[1:0] == 2'b01) ? 2'b01 : 2'b00};
`else
  assign trap_target = trap_base;
  assign mtvec_wdata = {i_CsrWriteData[XLEN-1:2], 2'b00};
`endif

  assign mstatus_view = {{(XLEN-13){1'b0}}, 2'b11, 3'b000, mpie, 3'b000, mie, 3'b000};

  // State register
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (trap_take || mret_take) begin
          state_next = S_REDIRECT;
        end
      end
      S_REDIRECT: begin
        if (i_RedirectReady) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    o_Busy          = 1'b0;
    o_RedirectValid = 1'b0;
    case (state)
      S_REDIRECT: begin
        o_Busy          = 1'b1;
        o_RedirectValid = 1'b1;
      end
      default: begin
        o_Busy          = 1'b0;
        o_RedirectValid = 1'b0;
      end
    endcase
  end

  assign o_RedirectPC        = redirect_pc;
  assign o_InterruptsEnabled = mie;

  // Trap CSRs and redirect target
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      mepc        <= '0;
      mcause      <= '0;
      mtval       <= '0;
      mtvec       <= MTVEC_RESET;
      mie         <= 1'b0;
      mpie        <= 1'b0;
      redirect_pc <= '0;
    end else if (trap_take) begin
      mepc        <= {i_TrapPC[XLEN-1:2], 2'b00};
      mcause      <= {i_Interrupt, {(XLEN-5){1'b0}}, i_ExceptionCause};
      mtval       <= i_TrapValue;
      mpie        <= mie;
      mie         <= 1'b0;
      redirect_pc <= trap_target;
    end else if (mret_take) begin
      mie         <= mpie;
      mpie        <= 1'b1;
      redirect_pc <= mepc;
    end else if (csr_write) begin
      case (i_CsrAddress)
        CSR_MSTATUS: begin
          mie  <= i_CsrWriteData[3];
          mpie <= i_CsrWriteData[7];
        end
        CSR_MTVEC:  mtvec  <= mtvec_wdata;
        CSR_MEPC:   mepc   <= {i_CsrWriteData[XLEN-1:2], 2'b00};
        CSR_MCAUSE: mcause <= i_CsrWriteData;
        CSR_MTVAL:  mtval  <= i_CsrWriteData;
        default: ;
      endcase
    end
  end

  // CSR read port
  always_comb begin
    o_CsrReadData = '0;
    o_CsrHit      = 1'b1;
    case (i_CsrAddress)
      CSR_MSTATUS: o_CsrReadData = mstatus_view;
      CSR_MTVEC:   o_CsrReadData = mtvec;
      CSR_MEPC:    o_CsrReadData = mepc;
      CSR_MCAUSE:  o_CsrReadData = mcause;
      CSR_MTVAL:   o_CsrReadData = mtval;
      default: begin
        o_CsrReadData = '0;
        o_CsrHit      = 1'b0;
      end
    endcase
  end

  logic unused_bits;
  assign unused_bits = &{1'b0, i_TrapPC[1:0], i_CsrWriteData[1:0]};

endmodule

`default_nettype wire
